ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Front-end controller for the 64x8 single-port RAM, which has a registered read address, one write port and read data valid one cycle after the address.
- After every reset, clears the whole RAM to INIT_VAL. Then shares the single port between two requesters (A, B) with round-robin arbitration and a req/gnt handshake.
- Returns read data with a one-cycle rvalid strobe to the granted requester.
- Sits between the two client blocks and the RAM instance; the RAM itself is external.

Parameters:
- ADDR_W, 6, RAM address width (depth = 2**ADDR_W = 64)
- DATA_W, 8, RAM data width
- INIT_VAL, 8'h00, value written to every word during the init sweep

Ports:
- clk, input, 1, single clock; all state updates on rising edge
- rst_n, input, 1, reset, synchronous and active-low
- init_done, output, 1, high once the clear sweep has completed
- a_req, input, 1, requester A access request
- a_we, input, 1, A: 1 = write, 0 = read
- a_addr, input, ADDR_W, A address
- a_wdata, input, DATA_W, A write data
- a_gnt, output, 1, A granted this cycle (combinational)
- a_rvalid, output, 1, A read data valid (registered)
- a_rdata, output, DATA_W, A read data (= ram_q)
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical set for requester B
- ram_data, output, DATA_W, to RAM data
- ram_addr, output, ADDR_W, to RAM addr
- ram_we, output, 1, to RAM we
- ram_q, input, DATA_W, from RAM q

Behaviour:
- State registers:
  - state: INIT or SERVE
  - init_cnt: ADDR_W bits
  - prio: 0 = A, 1 = B
  - rv_a, rv_b
- Reset (rst_n low at a rising edge):
  - state <= INIT, init_cnt <= 0, prio <= A, rv_a/rv_b <= 0.
  - While rst_n is low: init_done=0, gnt=0, rvalid=0, ram_we=0, ram_addr=0, ram_data=0 (outputs forced combinationally).
- INIT state:
  - ram_we=1, ram_addr=init_cnt, ram_data=INIT_VAL.
  - Each edge: init_cnt+1. On the edge that writes address 63, state <= SERVE.
  - The sweep takes exactly 64 cycles; gnt stays 0 and requests wait.
- init_done:
  - Registered, equal to (state==SERVE).
  - Rises on the 64th rising edge after the first edge with rst_n high.
- SERVE arbitration (combinational, same cycle):
  - Only one request asserted: that requester wins.
  - Both asserted: the requester named by prio wins.
  - Neither asserted: ram_we=0, ram_addr=0, ram_data=0, no grant.
  - Exactly one of a_gnt/b_gnt may be high at a time; a gnt is never high without its req.
- RAM drive: ram_addr, ram_we and ram_data come from the winner's addr, we and wdata in the cycle of grant.
- Priority update: on every edge with a grant, prio <= the requester not granted. prio is unchanged when idle.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high at a rising edge.
  - The transaction completes on that edge; the requester may drop req or present a new request the next cycle.
  - Back-to-back grants are allowed every cycle, giving 1 access per cycle throughput.
- Read response:
  - rv_x <= (x_gnt && !x_we) on each edge; x_rvalid = rv_x.
  - x_rdata = ram_q, meaningful only while x_rvalid=1.
  - Latency: 1 cycle from the grant edge.
  - No rvalid is generated for writes.
- Same address written then read in the next cycle: the read returns the newly written data, because of the RAM's registered read address.
- Reset mid-operation:
  - Any pending rvalid is dropped.
  - prio returns to A and the INIT sweep restarts from address 0.
  - Transactions granted before reset are not re-issued.
- Address and count arithmetic is unsigned ADDR_W; init_cnt wraps to 0 after 63 and is unused in SERVE.

Test Plan:
- Reset 3 cycles then release, no requests -> ram_we=1 for exactly 64 cycles with ram_addr 0..63 and ram_data 8'h00; init_done rises on the 64th edge; read of addr 6'd17 afterwards gives rdata 8'h00.
- A writes 8'hA5 to addr 6'd5, next cycle A reads addr 6'd5 -> a_gnt high both cycles; a_rvalid high one cycle after the read grant with a_rdata=8'hA5; b_rvalid stays 0.
- A and B both hold read requests for 4 cycles after reset -> grants in order A,B,A,B; each requester receives rvalid one cycle after each of its grants.
- B alone requests 3 consecutive cycles with prio at A -> b_gnt high all 3 cycles (no idle bubbles); prio=A after the last B grant.
- Request asserted during INIT (a_req=1, read addr 6'd9) -> a_gnt=0 until the cycle init_done=1, then granted the same cycle and returns 8'h00.
- rst_n pulsed low for 1 cycle the cycle after a B read grant -> b_rvalid never asserts; INIT restarts at ram_addr=0; a previously written 8'h3C at addr 6'd2 reads back 8'h00.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Front end for a single-port RAM. After reset it clears every word to INIT_VAL,
// then shares the port between requesters A and B with round-robin priority.
module ram_port_arbiter #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic {INIT, SERVE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] init_cnt_reg;
  logic              prio_reg;  // 0 = A preferred, 1 = B preferred
  logic              rv_a_reg, rv_b_reg;
  logic              serving, win_a, win_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      prio_reg     <= 1'b0;
      rv_a_reg     <= 1'b0;
      rv_b_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == INIT)
        init_cnt_reg <= init_cnt_reg + 1'b1;
      // Hand priority to whichever side was not just served.
      if (win_a || win_b)
        prio_reg <= win_a;
      rv_a_reg <= win_a && !a_we;
      rv_b_reg <= win_b && !b_we;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == INIT && init_cnt_reg == '1)
      state_next = SERVE;
  end

  assign serving = rst_n && (state_reg == SERVE);
  assign win_a   = serving && a_req && (!b_req || !prio_reg);
  assign win_b   = serving && b_req && (!a_req || prio_reg);

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (rst_n) begin
      if (state_reg == INIT) begin
        ram_we   = 1'b1;
        ram_addr = init_cnt_reg;
        ram_data = INIT_VAL;
      end else if (win_a) begin
        ram_we   = a_we;
        ram_addr = a_addr;
        ram_data = a_wdata;
      end else if (win_b) begin
        ram_we   = b_we;
        ram_addr = b_addr;
        ram_data = b_wdata;
      end
    end
  end

  assign init_done = serving;
  assign a_gnt     = win_a;
  assign b_gnt     = win_b;
  assign a_rvalid  = rst_n && rv_a_reg;
  assign b_rvalid  = rst_n && rv_b_reg;
  assign a_rdata   = ram_q;
  assign b_rdata   = ram_q;

endmodule
